// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage (master)
// and the data memory (slave).
interface mem_wb_stage_if #(
    parameter int DATA_W = 24
);
    logic              memReq;
    logic              memWe;
    logic [15:0]       memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memAck;
    logic [DATA_W-1:0] memRData;

    modport master (
        output memReq, memWe, memAddr, memWData,
        input  memAck, memRData
    );

    modport slave (
        input  memReq, memWe, memAddr, memWData,
        output memAck, memRData
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage of the 24-bit core: M register, data-memory
// handshake with stall and timeout, and the registered write-back bundle.
module mem_wb_stage #(
    parameter int MAX_WAIT = 15,
    parameter int DATA_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validE,
    input  logic [DATA_W-1:0] aluResE,
    input  logic [DATA_W-1:0] writeDataE,
    input  logic              regWriteE,
    input  logic              memToRegE,
    input  logic              memWriteE,
    input  logic              PCSrcE,
    input  logic [3:0]        WA3E,
    mem_wb_stage_if.master    mem,
    output logic              stallM,
    output logic [DATA_W-1:0] resultW,
    output logic [3:0]        WA3W,
    output logic              regWriteW,
    output logic              PCSrcW,
    output logic              memErr
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              validM, regWriteM, memToRegM, memWriteM, PCSrcM;
    logic [DATA_W-1:0] aluResM, writeDataM;
    logic [3:0]        WA3M;
    logic [3:0]        waitCnt;
    logic              memOpM;
    logic              timeout;

    // A timed-out load returns zero rather than whatever is on the read bus.
    function automatic logic [DATA_W-1:0] wb_data(
        input logic              to_reg,
        input logic              tmo,
        input logic [DATA_W-1:0] rdata,
        input logic [DATA_W-1:0] alu
    );
        if (!to_reg) return alu;
        return tmo ? '0 : rdata;
    endfunction

    assign memOpM  = validM & (memToRegM | memWriteM);
    assign timeout = memOpM & ~mem.memAck & (waitCnt == WAIT_LAST);
    assign stallM  = memOpM & ~mem.memAck & ~timeout;

    assign mem.memReq   = memOpM;
    assign mem.memWe    = memWriteM;
    assign mem.memAddr  = aluResM[15:0];
    assign mem.memWData = writeDataM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mem.memReq & ~mem.memAck) state_d = WAIT;
            WAIT:    if (mem.memAck | timeout)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- E -> M boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validM     <= 1'b0;
            regWriteM  <= 1'b0;
            memToRegM  <= 1'b0;
            memWriteM  <= 1'b0;
            PCSrcM     <= 1'b0;
            aluResM    <= '0;
            writeDataM <= '0;
            WA3M       <= '0;
        end else if (!stallM) begin
            validM     <= validE;
            regWriteM  <= regWriteE;
            memToRegM  <= memToRegE;
            memWriteM  <= memWriteE;
            PCSrcM     <= PCSrcE;
            aluResM    <= aluResE;
            writeDataM <= writeDataE;
            WA3M       <= WA3E;
        end
    end

    // Counts unacknowledged request cycles; stallM already implies req & ~ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= '0;
        end else if (stallM) begin
            waitCnt <= waitCnt + 4'd1;
        end else begin
            waitCnt <= '0;
        end
    end

    // ---- M -> W boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resultW   <= '0;
            WA3W      <= '0;
            regWriteW <= 1'b0;
            PCSrcW    <= 1'b0;
            memErr    <= 1'b0;
        end else begin
            if (timeout) memErr <= 1'b1;
            if (!stallM) begin
                resultW   <= wb_data(memToRegM, timeout, mem.memRData, aluResM);
                WA3W      <= WA3M;
                regWriteW <= validM & regWriteM & ~(memToRegM & timeout);
                PCSrcW    <= validM & PCSrcM;
            end else begin
                // Bubble so a stalled instruction cannot write back twice.
                regWriteW <= 1'b0;
                PCSrcW    <= 1'b0;
            end
        end
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back pipeline stage of the 24-bit processor. It sits directly downstream of the execute datapath and captures the execute-stage result, store data and control bits into an M register. It performs the data-memory access over a req/ack handshake, with stall and timeout. It then presents the registered write-back bundle (`resultW`, `WA3W`, `regWriteW`, `PCSrcW`) that feeds the register file and next-PC mux upstream.

## Interface
- `MAX_WAIT`, default 15: maximum cycles a request may stay unacknowledged (1..15).
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-low.
- `validE`  in  1  Execute stage holds a real instruction (0 = bubble).
- `aluResE`  in  24  Post-ALU result; bits [15:0] are the memory address.
- `writeDataE`  in  24  Store data (execute `srcB`).
- `regWriteE`, `memToRegE`, `memWriteE`, `PCSrcE`  in  1 each  Conditioned control bits from execute.
- `WA3E`  in  4  Destination register.
- `memReq`  out  1  Memory request.
- `memWe`  out  1  1 = store, 0 = load.
- `memAddr`  out  16  Access address.
- `memWData`  out  24  Store data.
- `memAck`  in  1  Memory completed the request this cycle.
- `memRData`  in  24  Load data; valid when `memAck`=1 and `memWe`=0.
- `stallM`  out  1  Upstream stages (E, D, F) must hold.
- `resultW`  out  24  Write-back data.
- `WA3W`  out  4  Write-back register.
- `regWriteW`  out  1  Register-file write enable.
- `PCSrcW`  out  1  Write-back result is the next PC.
- `memErr`  out  1  Sticky timeout flag.

## Operation
- **M register** (`validM`, `aluResM`, `writeDataM`, control bits, `WA3M`) loads the E inputs at each edge where `stallM`=0. It holds its value while `stallM`=1.
- **Memory-op condition:** `memOpM = validM & (memToRegM | memWriteM)`.
- **Request outputs (combinational from the M register):**
  - `memReq = memOpM`
  - `memWe = memWriteM`
  - `memAddr = aluResM[15:0]`
  - `memWData = writeDataM`
  - These are stable while the request is held.
- **Stall (combinational):** `stallM = memOpM & ~memAck & ~timeout`.
- **Wait counter (4 bits):**
  - Cleared whenever M advances.
  - Increments at each edge where `memReq`=1 and `memAck`=0.
  - `timeout = memOpM & ~memAck & (waitCnt == MAX_WAIT-1)`.
- **FSM:**
  - States: IDLE, WAIT.
  - IDLE → WAIT: `memReq` & ~`memAck`.
  - WAIT → IDLE: `memAck` or `timeout`.
  - IDLE → IDLE: zero-wait ack or no memory op.
- **Timeout handling:**
  - M advances as if acknowledged.
  - A load's register write is suppressed and its `resultW` is 0.
  - A store is considered dropped.
  - `memErr` is set and stays set until reset.
- **W register, when `stallM`=0 at an edge:**
  - `resultW` ← `memToRegM ? (timeout ? 0 : memRData) : aluResM`
  - `WA3W` ← `WA3M`
  - `regWriteW` ← `validM & regWriteM & ~(memToRegM & timeout)`
  - `PCSrcW` ← `validM & PCSrcM`
- **W register, when `stallM`=1 at an edge:** a bubble is inserted (`regWriteW`=0, `PCSrcW`=0; `resultW`/`WA3W` keep their values). This prevents the same instruction from writing twice.
- **Stores:** never assert `regWriteW` unless `regWriteE` was set. `memToRegE`=1 with `memWriteE`=1 is illegal input; `memWe`=1 takes priority.

## Timing
- **Reset values:** `validM`, control bits, `memReq`, `stallM`, `regWriteW`, `PCSrcW`, `memErr`, `waitCnt` = 0; `resultW`, `WA3W`, `memAddr`, `memWData` = 0; FSM = IDLE.
- **Reset asserted mid-request:** `memReq` drops immediately (asynchronously); the memory side abandons the access.
- **Non-memory op:** enters M at edge 1; `resultW` is valid after edge 2 (latency 2).
- **Memory op:** the request starts in the cycle after edge 1.
  - Ack in that same cycle: zero stall.
  - Ack k cycles later: `stallM` high exactly k cycles.
- **Handshake:** `memAck` is sampled only while `memReq`=1; `memAck` without `memReq` is ignored.
- **Back-to-back memory ops:** allowed; `memReq` may stay high across consecutive instructions when each is acked.
- **Timeout:** `memReq` is high for exactly `MAX_WAIT` cycles and `stallM` for `MAX_WAIT-1` cycles; M advances at the edge closing the last cycle.

## Test plan
- **Reset:** `rst`=0 with random inputs → all outputs 0 and `memReq`=0. Asserting `rst` while `memReq`=1 drops `memReq` the same cycle.
- **ALU op:** `validE`=1, `aluResE`=0x00ABCD, `regWriteE`=1, `WA3E`=5 → after edge 2, `resultW`=0x00ABCD, `WA3W`=5, `regWriteW`=1 for one cycle; `memReq` stays 0.
- **Load with delayed ack:** `memToRegE`=1, `aluResE`=0x000010, `WA3E`=3; `memAck` in the 3rd request cycle with `memRData`=0x123456 → `memAddr`=0x0010, `stallM` high 2 cycles, then `resultW`=0x123456, `regWriteW`=1 once.
- **Zero-wait store:** `memWriteE`=1, `writeDataE`=0xFEDCBA, `aluResE`=0x0020, `memAck` tied 1 → `memWe`=1, `memWData`=0xFEDCBA, no stall, `regWriteW`=0.
- **Timeout:** load with `memAck` stuck at 0, `MAX_WAIT`=15 → `memReq` high 15 cycles, `memErr`=1 thereafter, `regWriteW`=0 for the load, and the next ALU op writes back normally.
- **Back-to-back with branch:** two loads acked at 0 and 2 wait cycles, followed by an op with `PCSrcE`=1 → `PCSrcW`=1 for exactly one cycle, with no duplicate write-back during stalls.
